rr_arbiter_8: RTL

//  Round-robin arbiter granting one shared resource to 8 requesters (REQ[7:0]).

---
 rtl/rr_arbiter_8_pkg.sv | 24 ++
 rtl/rr_arbiter_8_pick.sv | 46 ++++
 rtl/rr_arbiter_8.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// -----------------------------------------------------------------------------
// rr_arbiter_8_pkg
//   Shared definitions for the 8-way round-robin arbiter: requester count,
//   index width, FSM state encoding and a one-hot helper.
// -----------------------------------------------------------------------------
package rr_arbiter_8_pkg;

    localparam int NREQ = 8;
    localparam int IDW  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    function automatic logic [NREQ-1:0] id_to_onehot(input logic [IDW-1:0] id);
        logic [NREQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_pick.sv
// -----------------------------------------------------------------------------
// rr_arbiter_8_pick
//   Combinational round-robin winner selection. The request vector is rotated
//   right by PTR so that requester PTR lands in bit 0, the lowest set bit is
//   priority-encoded, and PTR is added back (mod 8) to recover the absolute
//   requester index.
//
// Ports
//   REQ        in   8  request lines
//   PTR        in   3  requester with highest priority this round
//   WIN_ID     out  3  absolute index of the winner (0 when nothing requests)
//   WIN_VALID  out  1  at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter_8_pick
    import rr_arbiter_8_pkg::*;
(
    input  logic [NREQ-1:0] REQ,
    input  logic [IDW-1:0]  PTR,
    output logic [IDW-1:0]  WIN_ID,
    output logic            WIN_VALID
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [IDW-1:0]    rot_idx;

    // Doubling the vector turns the rotate into a plain indexed part-select:
    // req_rot[k] = REQ[(k + PTR) mod 8].
    assign req_dbl = {REQ, REQ};
    assign req_rot = req_dbl[PTR +: NREQ];

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        rot_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                rot_idx = IDW'(k);
            end
        end
    end

    // Three-bit addition wraps naturally, giving the mod-8 add-back.
    assign WIN_ID    = rot_idx + PTR;
    assign WIN_VALID = |REQ;

endmodule

// File: rtl/rr_arbiter_8.sv
// -----------------------------------------------------------------------------
// rr_arbiter_8
//   Round-robin arbiter for one shared resource and 8 requesters. Drives the
//   one-hot select of the shared datapath. A holder keeps the grant until it
//   asserts DONE, drops its request, or reaches HOLD_MAX cycles. Every grant
//   is followed by one dead (GAP) cycle for resource turnaround and one IDLE
//   cycle in which requests are re-arbitrated from the requester after the
//   last holder.
//
// Parameters
//   HOLD_MAX   max cycles a grant may be held; 0 disables the limit
//   CNT_W      hold counter width; HOLD_MAX must fit in CNT_W bits
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   REQ        in   8  level-sensitive requests
//   DONE       in   1  holder finished (only looked at while granting)
//   GNT        out  8  registered one-hot grant, zero when idle
//   GNT_VALID  out  1  registered, high iff GNT is non-zero
//   GNT_ID     out  3  registered holder index, zero when no grant
//   ANY_REQ    out  1  combinational OR of REQ
//   TIMEOUT    out  1  registered pulse in the cycle after a forced release
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no grant; arbitrate REQ from PTR on the next edge
// S_GRANT | GNT driven to one holder; hold counter running
// S_GAP   | single dead cycle after a release, GNT=0
// -----------------------------------------------------------------------------
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] REQ,
    input  logic            DONE,
    output logic [NREQ-1:0] GNT,
    output logic            GNT_VALID,
    output logic [IDW-1:0]  GNT_ID,
    output logic            ANY_REQ,
    output logic            TIMEOUT
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam bit               LIMIT_EN = (HOLD_MAX != 0);

    // ------------------------------------------------------------------
    // Request OR tree
    // ------------------------------------------------------------------
    logic [3:0] or_l1;
    logic [1:0] or_l2;

    assign or_l1[0] = REQ[0] | REQ[1];
    assign or_l1[1] = REQ[2] | REQ[3];
    assign or_l1[2] = REQ[4] | REQ[5];
    assign or_l1[3] = REQ[6] | REQ[7];
    assign or_l2[0] = or_l1[0] | or_l1[1];
    assign or_l2[1] = or_l1[2] | or_l1[3];
    assign ANY_REQ  = or_l2[0] | or_l2[1];

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t           state_q,   state_nxt;
    logic [IDW-1:0]   ptr_q,     ptr_nxt;
    logic [CNT_W-1:0] cnt_q,     cnt_nxt;
    logic [NREQ-1:0]  gnt_q,     gnt_nxt;
    logic             valid_q,   valid_nxt;
    logic [IDW-1:0]   id_q,      id_nxt;
    logic             timeout_q, timeout_nxt;

    logic [IDW-1:0]   win_id;
    logic             win_valid;
    logic             hold_hit;
    logic             release_now;

    rr_arbiter_8_pick u_pick (
        .REQ       (REQ),
        .PTR       (ptr_q),
        .WIN_ID    (win_id),
        .WIN_VALID (win_valid)
    );

    // The hold counter holds the number of GRANT cycles seen so far,
    // including the current one, so reaching the limit here means this is
    // the last permitted cycle.
    assign hold_hit    = LIMIT_EN && (cnt_q == HOLD_LIM);
    assign release_now = DONE || !REQ[id_q] || hold_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            ptr_q     <= ptr_nxt;
            cnt_q     <= cnt_nxt;
            gnt_q     <= gnt_nxt;
            valid_q   <= valid_nxt;
            id_q      <= id_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        ptr_nxt     = ptr_q;
        cnt_nxt     = cnt_q;
        gnt_nxt     = gnt_q;
        valid_nxt   = valid_q;
        id_nxt      = id_q;
        timeout_nxt = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    state_nxt = S_GRANT;
                    gnt_nxt   = id_to_onehot(win_id);
                    valid_nxt = 1'b1;
                    id_nxt    = win_id;
                    cnt_nxt   = CNT_W'(1);
                end
            end

            S_GRANT: begin
                if (release_now) begin
                    // DONE and a timeout in the same cycle still produce a
                    // single release; TIMEOUT reports the limit either way.
                    state_nxt   = S_GAP;
                    gnt_nxt     = '0;
                    valid_nxt   = 1'b0;
                    id_nxt      = '0;
                    ptr_nxt     = id_q + IDW'(1);
                    cnt_nxt     = '0;
                    timeout_nxt = hold_hit;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            S_GAP: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
                valid_nxt = 1'b0;
                id_nxt    = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign GNT       = gnt_q;
    assign GNT_VALID = valid_q;
    assign GNT_ID    = id_q;
    assign TIMEOUT   = timeout_q;

endmodule
